serv_dbus_ram: RTL and testbench

SERV_DBUS_RAM -- requirements
Module: serv_dbus_ram

---
 rtl/serv_dbus_pkg.sv | 26 ++
 rtl/serv_dbus_ram_array.sv | 29 ++
 rtl/serv_dbus_ram.sv | 115 +++++++++++
 tb/tb_serv_dbus_ram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the SERV data-bus RAM: FSM states, legal
// byte-lane patterns and the wait-state limit.
package serv_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    localparam int MAX_WAIT_STATES = 15;

    // Only naturally aligned byte, halfword and word accesses are accepted.
    function automatic logic sel_legal(input logic [3:0] sel);
        return sel inside {SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W};
    endfunction

endpackage

// File: rtl/serv_dbus_ram_array.sv
// Word-organised storage with per-byte write strobes and a registered read
// port. Contents are deliberately not reset.
module serv_dbus_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdat,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdat
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
        if (re) begin
            rdat <= mem[raddr];
        end
    end

endmodule

// File: rtl/serv_dbus_ram.sv
// Wishbone-style data-bus RAM for SERV: one request at a time, optional wait
// states, error completion for illegal lane patterns or out-of-range words.
module serv_dbus_ram
    import serv_dbus_pkg::*;
#(
    parameter  int DEPTH       = 256,
    parameter  int WAIT_STATES = 0,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int         WS        = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [3:0] WAIT_LOAD = (WS > 0) ? 4'(WS - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic [29:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        req_err;
    logic [3:0]  wr_en;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        unused_adr;

    assign unused_adr = ^i_wb_adr[1:0];

    // Checks run on the latched request so late input changes cannot matter.
    assign req_err = !sel_legal(sel_q) || (adr_q[29:AW] != '0);
    assign wr_en   = (state == RESP && we_q && !req_err) ? sel_q : 4'b0000;

    // The array is read at the sample edge so the word is ready by RESP.
    assign rd_en   = (state == IDLE) && i_wb_cyc && i_wb_stb;

    serv_dbus_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (adr_q[AW-1:0]),
        .wdat  (dat_q),
        .re    (rd_en),
        .raddr (i_wb_adr[AW+1:2]),
        .rdat  (rd_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        adr_q <= i_wb_adr[31:2];
                        dat_q <= i_wb_dat;
                        sel_q <= i_wb_sel;
                        we_q  <= i_wb_we;
                        if (WS > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!i_wb_cyc) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (req_err) begin
                        o_wb_err <= 1'b1;
                    end else begin
                        o_wb_ack <= 1'b1;
                        if (!we_q) begin
                            o_wb_rdt <= rd_data;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Bench for serv_dbus_ram: one instance with no wait states, one with three,
// directed corner cases plus randomized traffic against a word-array model.
module tb_serv_dbus_ram;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        cyc [2];
    logic        stb [2];
    logic [31:0] rdt [2];
    logic        ack [2];
    logic        err [2];

    always #5 clk = ~clk;

    serv_dbus_ram #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]),
        .i_wb_sel(sel[0]), .i_wb_we(we[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
        .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0])
    );

    serv_dbus_ram #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_rst(rst[1]), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]),
        .i_wb_sel(sel[1]), .i_wb_we(we[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
        .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1])
    );

    // Reference model: memory image and last-read value per instance.
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] model_rdt [2];
    logic [31:0] exp_q [$];
    logic [3:0]  legal_sel [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit sel_ok(input logic [3:0] s);
        for (int i = 0; i < 7; i++) begin
            if (s == legal_sel[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One complete request; called and returns on a falling edge.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bit   exp_err;
        bit   done;
        int   n;
        int   idx;
        logic r_ack;
        logic r_err;
        exp_err = !sel_ok(s) || (a[31:2] >= DEPTH);
        idx     = int'(a[9:2]);
        if (!w && !exp_err) exp_q.push_back(model_mem[k][idx]);
        adr[k] = a; dat[k] = d; sel[k] = s; we[k] = w;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        n = 0; done = 1'b0; r_ack = 1'b0; r_err = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                adr[k] = $urandom; dat[k] = $urandom;
                sel[k] = 4'($urandom); we[k] = 1'($urandom);
            end
            if (ack[k] || err[k]) begin
                done = 1'b1; r_ack = ack[k]; r_err = err[k];
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        check($sformatf("done_%0d", k), 32'(done), 32'd1);
        check($sformatf("latency_%0d", k), 32'(n - 1), 32'(ws(k) + 1));
        check($sformatf("ack_err_%0d_%h", k, a), {30'd0, r_ack, r_err},
              exp_err ? 32'd1 : 32'd2);
        if (!exp_err && w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_mem[k][idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        if (!exp_err && !w) model_rdt[k] = exp_q.pop_front();
        check($sformatf("rdt_%0d_%h", k, a), rdt[k], model_rdt[k]);
    endtask

    task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] d);
        int seen;
        seen = 0;
        adr[k] = a; dat[k] = d; sel[k] = 4'hF; we[k] = 1'b1;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (ack[k] || err[k]) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_rdt", rdt[k], model_rdt[k]);
    endtask

    task automatic reset_during_wait(input int k, input logic [31:0] a, input logic [31:0] d);
        adr[k] = a; dat[k] = d; sel[k] = 4'hF; we[k] = 1'b1;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk);
        #2 rst[k] = 1'b1;
        #1;
        check("rst_ack", 32'(ack[k]), 32'd0);
        check("rst_err", 32'(err[k]), 32'd0);
        check("rst_rdt", rdt[k], 32'd0);
        model_rdt[k] = 32'd0;
        @(negedge clk);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        rst[k] = 1'b0;
    endtask

    task automatic hold_request(input int k, input logic [31:0] a);
        int period;
        int acks;
        int errs;
        int last;
        int min_gap;
        period = ws(k) + 2;
        acks = 0; errs = 0; last = -1; min_gap = 1000;
        adr[k] = a; dat[k] = 32'd0; sel[k] = 4'hF; we[k] = 1'b0;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int e = 1; e <= period * 5; e++) begin
            @(posedge clk); @(negedge clk);
            if (err[k]) errs++;
            if (ack[k]) begin
                acks++;
                if (last >= 0 && e - last < min_gap) min_gap = e - last;
                last = e;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        model_rdt[k] = model_mem[k][int'(a[9:2])];
        check($sformatf("hold_acks_%0d", k), 32'(acks), 32'd5);
        check($sformatf("hold_errs_%0d", k), 32'(errs), 32'd0);
        check($sformatf("hold_gap_%0d", k), 32'(min_gap), 32'(period));
        check($sformatf("hold_rdt_%0d", k), rdt[k], model_rdt[k]);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          k;
        for (int j = 0; j < 2; j++) begin
            rst[j] = 1'b1; adr[j] = '0; dat[j] = '0; sel[j] = '0;
            we[j] = 1'b0; cyc[j] = 1'b0; stb[j] = 1'b0; model_rdt[j] = '0;
        end
        repeat (2) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("reset_ack_%0d", j), 32'(ack[j]), 32'd0);
            check($sformatf("reset_err_%0d", j), 32'(err[j]), 32'd0);
            check($sformatf("reset_rdt_%0d", j), rdt[j], 32'd0);
            rst[j] = 1'b0;
        end

        // Pre-fill the words the random traffic touches.
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 16; i++) xfer(j, 1'b1, 32'(i * 4), $urandom, 4'hF);
            xfer(j, 1'b1, 32'h3FC, $urandom, 4'hF);
        end

        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
        check("deadbeef", rdt[0], 32'hDEADBEEF);

        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b1100);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'b0001);
        check("lanes_1100", rdt[0], 32'hAABB3344);

        xfer(0, 1'b1, 32'h20, 32'h55555555, 4'b0101);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF);
        check("bad_sel_nowrite", rdt[0], 32'hAABB3344);
        xfer(0, 1'b0, 32'h400, 32'h0, 4'hF);

        xfer(1, 1'b1, 32'h30, 32'h12345678, 4'hF);
        abort_write(1, 32'h30, 32'h0BADF00D);
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF);
        check("abort_nowrite", rdt[1], 32'h12345678);

        reset_during_wait(1, 32'h30, 32'hCAFEF00D);
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF);
        check("rst_nowrite", rdt[1], 32'h12345678);

        hold_request(0, 32'h20);
        hold_request(1, 32'h30);

        for (int t = 0; t < 200; t++) begin
            k = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(256, 1023) * 4);
                1:       a = 32'h3FC;
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) s = 4'($urandom);
            else s = legal_sel[$urandom_range(0, 6)];
            xfer(k, 1'($urandom), a, $urandom, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
